// File: rtl/gj_axis_uart_regs_mc.sv
// Multi-channel AXIS UART register bank: one BRAM-style port fans out to NUM_CH
// per-channel register sets with W1C interrupt status and saturating counters.

package gj_axis_uart_regs_mc_pkg;
  typedef struct packed {
    logic        wr;
    logic [3:0]  off;
    logic [3:0]  we;
    logic [31:0] wdata;
  } reg_req_t;

  typedef struct packed {
    logic tx;
    logic rx;
    logic rx_err;
    logic start_err;
  } ch_evt_t;
endpackage

module gj_axis_uart_regs_ch
  import gj_axis_uart_regs_mc_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter logic [15:0] CLKDIV_RST = 16'd542
) (
  input  logic        clk,
  input  logic        rst_n,
  input  reg_req_t    req,
  input  ch_evt_t     evt,
  output logic        power_down,
  output logic        soft_rst,
  output logic [3:0]  mode,
  output logic [15:0] clk_div,
  output logic [15:0] tx_byte_nop,
  output logic [15:0] tx_frame_nop,
  output logic [15:0] max_rcv_gap,
  output logic [23:0] max_bytes,
  output logic        irq,
  output logic [31:0] rd_word
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PRE = {{(CNT_W-1){1'b1}}, 1'b0};

  logic [CNT_W-1:0] cnt [4];
  logic [15:0]      wsel;
  logic [4:0]       int_stat, int_en, stat_set, w1c;
  logic [3:0]       ev, cnt_clr, sat_hit;

  assign wsel = req.wr ? (16'd1 << req.off) : '0;
  // counter order follows offsets 8..11
  assign ev   = {evt.start_err, evt.rx & evt.rx_err, evt.rx, evt.tx};

  for (genvar k = 0; k < 4; k++) begin : g_cnt
    assign cnt_clr[k] = soft_rst | (wsel[8+k] & (|req.we));
    assign sat_hit[k] = ev[k] & ~cnt_clr[k] & (cnt[k] == CNT_PRE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (cnt_clr[k])                      cnt[k] <= '0;
        else if (ev[k] && cnt[k] != CNT_MAX) cnt[k] <= cnt[k] + CNT_W'(1);
      end
    end
  end

  assign stat_set = {|sat_hit, ev};
  assign w1c      = (wsel[4] & req.we[0]) ? req.wdata[4:0] : '0;
  assign irq      = |(int_stat & int_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      power_down   <= 1'b0;
      soft_rst     <= 1'b0;
      mode         <= '0;
      clk_div      <= CLKDIV_RST;
      tx_byte_nop  <= '0;
      tx_frame_nop <= '0;
      max_rcv_gap  <= '0;
      max_bytes    <= '0;
      int_stat     <= '0;
      int_en       <= '0;
    end else begin
      soft_rst <= wsel[0] & req.we[0] & req.wdata[1];
      // set wins over a coincident W1C
      int_stat <= (int_stat & ~w1c) | stat_set;
      if (wsel[0]) begin
        if (req.we[0]) power_down    <= req.wdata[0];
        if (req.we[1]) mode          <= req.wdata[11:8];
        if (req.we[2]) clk_div[7:0]  <= req.wdata[23:16];
        if (req.we[3]) clk_div[15:8] <= req.wdata[31:24];
      end
      if (wsel[1]) begin
        if (req.we[0]) tx_byte_nop[7:0]   <= req.wdata[7:0];
        if (req.we[1]) tx_byte_nop[15:8]  <= req.wdata[15:8];
        if (req.we[2]) tx_frame_nop[7:0]  <= req.wdata[23:16];
        if (req.we[3]) tx_frame_nop[15:8] <= req.wdata[31:24];
      end
      if (wsel[2]) begin
        if (req.we[0]) max_rcv_gap[7:0]  <= req.wdata[7:0];
        if (req.we[1]) max_rcv_gap[15:8] <= req.wdata[15:8];
      end
      if (wsel[3]) begin
        if (req.we[0]) max_bytes[7:0]   <= req.wdata[7:0];
        if (req.we[1]) max_bytes[15:8]  <= req.wdata[15:8];
        if (req.we[2]) max_bytes[23:16] <= req.wdata[23:16];
      end
      if (wsel[5] && req.we[0]) int_en <= req.wdata[4:0];
    end
  end

  always_comb begin
    rd_word = '0;
    case (req.off)
      4'd0:                      rd_word = {clk_div, 4'b0, mode, 7'b0, power_down};
      4'd1:                      rd_word = {tx_frame_nop, tx_byte_nop};
      4'd2:                      rd_word = {16'b0, max_rcv_gap};
      4'd3:                      rd_word = {8'b0, max_bytes};
      4'd4:                      rd_word = {27'b0, int_stat};
      4'd5:                      rd_word = {27'b0, int_en};
      4'd8, 4'd9, 4'd10, 4'd11:  rd_word = 32'(cnt[req.off[1:0]]);
      default:                   rd_word = '0;
    endcase
  end
endmodule

module gj_axis_uart_regs_mc
  import gj_axis_uart_regs_mc_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int CLKDIV_RST = 542,
  parameter int AW         = $clog2(NUM_CH) + 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bram_en,
  input  logic [AW-1:0]            bram_addr,
  input  logic [3:0]               bram_we,
  input  logic [31:0]              bram_wdata,
  output logic [31:0]              bram_rdata,
  output logic [NUM_CH-1:0]        powerDown,
  output logic [NUM_CH-1:0]        softRst,
  output logic [NUM_CH-1:0][3:0]   mode,
  output logic [NUM_CH-1:0][15:0]  clkDivX16,
  output logic [NUM_CH-1:0][15:0]  txByte_nop,
  output logic [NUM_CH-1:0][15:0]  txFrame_nop,
  output logic [NUM_CH-1:0][15:0]  maxRcvGap,
  output logic [NUM_CH-1:0][23:0]  maxBytesPerFrame,
  input  logic [NUM_CH-1:0]        txBytesInt,
  input  logic [NUM_CH-1:0]        rxBytesInt,
  input  logic [NUM_CH-1:0]        rxBytesError,
  input  logic [NUM_CH-1:0]        startError,
  output logic [NUM_CH-1:0]        irq
);
  logic [AW-1:0]            ch_sel;
  logic [NUM_CH-1:0][31:0]  rd_word;
  logic [31:0]              rd_mux;

  // channel field may decode past NUM_CH; such accesses hit no lane
  assign ch_sel = bram_addr >> 4;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    reg_req_t req;
    ch_evt_t  evt;
    assign req = '{wr: bram_en && (ch_sel == AW'(g)), off: bram_addr[3:0],
                   we: bram_we, wdata: bram_wdata};
    assign evt = '{tx: txBytesInt[g], rx: rxBytesInt[g],
                   rx_err: rxBytesError[g], start_err: startError[g]};

    gj_axis_uart_regs_ch #(.CNT_W(CNT_W), .CLKDIV_RST(16'(CLKDIV_RST))) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .evt         (evt),
      .power_down  (powerDown[g]),
      .soft_rst    (softRst[g]),
      .mode        (mode[g]),
      .clk_div     (clkDivX16[g]),
      .tx_byte_nop (txByte_nop[g]),
      .tx_frame_nop(txFrame_nop[g]),
      .max_rcv_gap (maxRcvGap[g]),
      .max_bytes   (maxBytesPerFrame[g]),
      .irq         (irq[g]),
      .rd_word     (rd_word[g])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (ch_sel == AW'(c)) rd_mux = rd_word[c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       bram_rdata <= '0;
    else if (bram_en) bram_rdata <= rd_mux;
  end
endmodule

// File: doc/gj_axis_uart_regs_mc.md
Name: gj_axis_uart_regs_mc

Overview:
Parametrised multi-channel register bank for the AXIS UART subsystem. It serves NUM_CH UART channels from one BRAM-style port and provides per-channel config, status counters and a maskable interrupt. Compared with the single-channel register block, it adds parametrised channel count and counter width, software-generated soft reset, W1C interrupt status, an interrupt enable per source, and saturating counters with an overflow flag. It sits between the AXI-BRAM controller and the channel TX/RX cores.

Parameters:
NUM_CH, 4, number of UART channels (1..16)
CNT_W, 32, status counter width (8..32)
CLKDIV_RST, 542, reset value of clkDivX16
AW, $clog2(NUM_CH)+4, word address width (derived; do not override)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
bram_en  in  1  access strobe
bram_addr  in  AW  word address = {channel, offset[3:0]}
bram_we  in  4  byte write enables
bram_wdata  in  32  write data
bram_rdata  out  32  read data
powerDown  out  NUM_CH  per-channel power down
softRst  out  NUM_CH  one-cycle soft reset pulse per channel
mode  out  4*NUM_CH  per-channel mode (same bit meaning as single-channel block)
clkDivX16  out  16*NUM_CH  per-channel baud divider
txByte_nop  out  16*NUM_CH  inter-byte idle bits
txFrame_nop  out  16*NUM_CH  inter-frame idle bits
maxRcvGap  out  16*NUM_CH  RX frame gap
maxBytesPerFrame  out  24*NUM_CH  RX frame length limit
txBytesInt  in  NUM_CH  TX byte done pulse
rxBytesInt  in  NUM_CH  RX byte done pulse
rxBytesError  in  NUM_CH  qualifies rxBytesInt as error
startError  in  NUM_CH  RX start-bit error pulse
irq  out  NUM_CH  per-channel interrupt, level

Behaviour:
- Per-channel map (offset): 0 CTRL {clkDivX16[31:16], mode[11:8], softRst[1] (W1 pulse, reads 0), powerDown[0]}; 1 NOP {txFrame_nop[31:16], txByte_nop[15:0]}; 2 GAP {maxRcvGap[15:0]}; 3 FRAME {maxBytesPerFrame[23:0]}; 4 INT_STAT[4:0]; 5 INT_EN[4:0]; 8 TXCNT; 9 RXCNT; 10 RXERRCNT; 11 STARTERRCNT; 6,7,12-15 reserved (read 0, writes ignored).
- Writes take effect on the clk edge with bram_en=1; each byte lane gated by bram_we[i]. Unused bits read 0.
- Read latency is 1 cycle: bram_rdata is registered on bram_en=1 and holds its value while bram_en=0. Writes and reads to the same address in the same cycle return the pre-write value.
- Channel index >= NUM_CH: reads return 0, writes are ignored.
- softRst[c]: a write of 1 to CTRL[1] with we[0] produces softRst[c]=1 for exactly the next cycle. Its clear effect on channel counters applies on that pulse cycle.
- INT_STAT bits: [0] txBytesInt, [1] rxBytesInt, [2] rxBytesInt&rxBytesError, [3] startError, [4] any counter saturated. A source event sets the bit. Writing 1 with we[0] clears the bit (W1C). If set and clear coincide in the same cycle, set wins.
- irq[c] = |(INT_STAT & INT_EN), driven from flops only with no combinational path from inputs.
- Counters are CNT_W bits wide and zero-extended on read. Each increments on its event and saturates at all-ones; the increment that reaches all-ones sets INT_STAT[4].
- Any write (any we bit) to a counter offset clears that counter. Priority: rst_n > softRst/clear > increment.
- Reset (async, rst_n=0): all outputs and registers are 0, except clkDivX16 = CLKDIV_RST. bram_rdata = 0. Reset mid-access discards the access.

Test Plan:
- Reset with NUM_CH=4 -> every clkDivX16 = 542, all other outputs 0; read ch2 off0 -> 0x021E0000 one cycle after bram_en.
- Write ch1 off1 0xAABB1234 with we=4'b0011 -> txByte_nop[1]=0x1234, txFrame_nop[1]=0; other channels unchanged.
- 3 rxBytesInt pulses on ch0, one with rxBytesError; INT_EN=0x6 -> RXCNT=3, RXERRCNT=1, irq[0]=1; W1C 0x6 -> irq[0]=0.
- CNT_W=8, 256 txBytesInt pulses on ch3 -> TXCNT=255, INT_STAT[4]=1; W1C of bit 0 coinciding with a txBytesInt -> bit 0 stays 1.
- Write CTRL[1]=1 on ch2 during a rxBytesInt -> softRst[2] high for 1 cycle, RXCNT[2]=0 afterwards; powerDown unchanged.
- NUM_CH=3: write to ch3 off0 -> no output changes; read -> 0.
